// File: rtl/lfsr_prng_stream_if.sv
// lfsr_prng_stream_if
//   Valid/ready word stream carrying pseudo-random words from the LFSR
//   generator to its consumer.
//   data   : OUT_BITS random word, driven by the master
//   valid  : data holds a complete word, driven by the master
//   ready  : consumer accepts data when high together with valid
interface lfsr_prng_stream_if #(
  parameter int OUT_BITS = 8
) ();
  logic [OUT_BITS-1:0] data;
  logic                valid;
  logic                ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/lfsr_prng_stream.sv
// lfsr_prng_stream
//   XNOR-feedback Fibonacci LFSR producing OUT_BITS-bit words on a
//   valid/ready stream. Seeds can be loaded at any time; the all-ones
//   lockup seed is replaced by DEFAULT_SEED and flagged. A shift that
//   returns the state to the stored seed pulses o_Wrap and records the
//   measured period.
// Ports
//   i_Clk        clock, rising edge
//   i_Rst        synchronous reset, active-high
//   i_Enable     1 = generator may shift
//   i_Seed_DV    single-cycle seed-load strobe
//   i_Seed_Data  seed value, sampled with i_Seed_DV
//   strm         stream master: data (LFSR LSBs), valid, ready
//   o_Wrap       1-cycle pulse when a shift returns the state to the seed
//   o_Period     shift count between seed load and the last wrap
//   o_Seed_Err   1-cycle pulse when an all-ones seed was rejected
//
// state  | meaning
// S_FILL | shifting OUT_BITS fresh bits into the word (while i_Enable)
// S_HOLD | word complete, valid high, shifting frozen until handshake
module lfsr_prng_stream #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'hD008,
  parameter int               OUT_BITS     = 8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = '0
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [WIDTH-1:0]    i_Seed_Data,
  lfsr_prng_stream_if.master  strm,
  output logic                o_Wrap,
  output logic [WIDTH-1:0]    o_Period,
  output logic                o_Seed_Err
);

  localparam int               BCW      = $clog2(OUT_BITS + 1);
  localparam logic [BCW-1:0]   LAST_BIT = BCW'(OUT_BITS - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic {S_FILL, S_HOLD} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_seed;
  logic [BCW-1:0]   r_bit_cnt;
  logic [WIDTH-1:0] r_shift_cnt;
  logic             r_valid;
  logic             w_fb;
  logic [WIDTH-1:0] w_lfsr_next;

  // XNOR feedback keeps all-zeros legal; all-ones is the lockup state.
  always_comb begin
    w_fb        = ~^(r_lfsr & TAPS);
    w_lfsr_next = {r_lfsr[WIDTH-2:0], w_fb};
  end

  assign strm.data  = r_lfsr[OUT_BITS-1:0];
  assign strm.valid = r_valid;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state     <= S_FILL;
      r_lfsr      <= DEFAULT_SEED;
      r_seed      <= DEFAULT_SEED;
      r_bit_cnt   <= '0;
      r_shift_cnt <= '0;
      r_valid     <= 1'b0;
      o_Wrap      <= 1'b0;
      o_Period    <= '0;
      o_Seed_Err  <= 1'b0;
    end else begin
      o_Wrap     <= 1'b0;
      o_Seed_Err <= 1'b0;
      if (i_Seed_DV) begin
        // Seed load discards any word in progress or held, even one
        // being handshaken this same cycle.
        if (i_Seed_Data == ALL_ONES) begin
          r_lfsr     <= DEFAULT_SEED;
          r_seed     <= DEFAULT_SEED;
          o_Seed_Err <= 1'b1;
        end else begin
          r_lfsr <= i_Seed_Data;
          r_seed <= i_Seed_Data;
        end
        r_state     <= S_FILL;
        r_bit_cnt   <= '0;
        r_shift_cnt <= '0;
        r_valid     <= 1'b0;
      end else begin
        case (r_state)
          S_FILL: begin
            if (i_Enable) begin
              r_lfsr    <= w_lfsr_next;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == LAST_BIT) begin
                r_state <= S_HOLD;
                r_valid <= 1'b1;
              end
              if (w_lfsr_next == r_seed) begin
                o_Wrap      <= 1'b1;
                o_Period    <= (r_shift_cnt == ALL_ONES) ? ALL_ONES
                                                         : r_shift_cnt + 1'b1;
                r_shift_cnt <= '0;
              end else if (r_shift_cnt != ALL_ONES) begin
                r_shift_cnt <= r_shift_cnt + 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (strm.ready) begin
              r_state   <= S_FILL;
              r_bit_cnt <= '0;
              r_valid   <= 1'b0;
            end
          end
          default: begin
            r_state <= S_FILL;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_prng_stream.sv
module tb_lfsr_prng_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // dut_a: 4-bit, 1 bit per word
  logic       en_a, sdv_a, wrap_a, serr_a;
  logic [3:0] sd_a, per_a;
  lfsr_prng_stream_if #(.OUT_BITS(1)) s_a ();
  lfsr_prng_stream #(.WIDTH(4), .TAPS(4'b1100), .OUT_BITS(1), .DEFAULT_SEED(4'b0000)) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en_a), .i_Seed_DV(sdv_a), .i_Seed_Data(sd_a),
    .strm(s_a), .o_Wrap(wrap_a), .o_Period(per_a), .o_Seed_Err(serr_a));

  // dut_b: 4-bit, whole state visible on data
  logic       en_b, sdv_b, wrap_b, serr_b;
  logic [3:0] sd_b, per_b;
  lfsr_prng_stream_if #(.OUT_BITS(4)) s_b ();
  lfsr_prng_stream #(.WIDTH(4), .TAPS(4'b1100), .OUT_BITS(4), .DEFAULT_SEED(4'b0000)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en_b), .i_Seed_DV(sdv_b), .i_Seed_Data(sd_b),
    .strm(s_b), .o_Wrap(wrap_b), .o_Period(per_b), .o_Seed_Err(serr_b));

  // dut_c: 16-bit default taps, 8 bits per word
  logic        en_c, sdv_c, wrap_c, serr_c;
  logic [15:0] sd_c, per_c;
  lfsr_prng_stream_if #(.OUT_BITS(8)) s_c ();
  lfsr_prng_stream #(.WIDTH(16), .TAPS(16'hD008), .OUT_BITS(8), .DEFAULT_SEED(16'h0000)) dut_c (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en_c), .i_Seed_DV(sdv_c), .i_Seed_Data(sd_c),
    .strm(s_c), .o_Wrap(wrap_c), .o_Period(per_c), .o_Seed_Err(serr_c));

  // 4-bit sequence from 0000 with taps at stages 3,4 (hand-computed).
  logic [3:0] seq4 [15] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6,
                            4'hC, 4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8};
  logic [3:0] exp_b [4];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    en_a = 0; sdv_a = 0; sd_a = '0; s_a.ready = 0;
    en_b = 0; sdv_b = 0; sd_b = '0; s_b.ready = 0;
    en_c = 0; sdv_c = 0; sd_c = '0; s_c.ready = 0;
    tick();
    tick();
    check("rst_valid",  32'(s_a.valid), 32'd0);
    check("rst_data",   32'(s_a.data),  32'd0);
    check("rst_wrap",   32'(wrap_a),    32'd0);
    check("rst_period", 32'(per_a),     32'd0);
    check("rst_serr",   32'(serr_a),    32'd0);
    check("rst_c_data", 32'(s_c.data),  32'd0);

    // Free run, one word per 2 cycles, wrap every 15 shifts.
    rst = 1'b0; en_a = 1; s_a.ready = 1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      check("a_valid", 32'(s_a.valid), 32'd1);
      check("a_data",  32'(s_a.data),  32'(seq4[k % 15][0]));
      check("a_wrap",  32'(wrap_a),    32'((k % 15) == 0));
      if ((k % 15) == 0) check("a_period", 32'(per_a), 32'd15);
      tick();
      check("a_gap_valid", 32'(s_a.valid), 32'd0);
      check("a_gap_wrap",  32'(wrap_a),    32'd0);
    end

    // Back-pressure: word held, no shifts, no wrap.
    s_a.ready = 0;
    tick();
    check("bp_valid0", 32'(s_a.valid), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_valid", 32'(s_a.valid), 32'd1);
      check("bp_data",  32'(s_a.data),  32'd1);
      check("bp_wrap",  32'(wrap_a),    32'd0);
    end
    s_a.ready = 1;
    for (int k = 2; k <= 4; k++) begin
      tick();
      check("bp_hs_valid", 32'(s_a.valid), 32'd0);
      tick();
      check("bp_rs_valid", 32'(s_a.valid), 32'd1);
      check("bp_rs_data",  32'(s_a.data),  32'(seq4[k][0]));
    end
    en_a = 0; s_a.ready = 0;

    // Lockup seed rejected, then a seed mid-FILL restarts the word.
    sdv_b = 1; sd_b = 4'hF;
    tick();
    check("serr_pulse", 32'(serr_b),    32'd1);
    check("serr_valid", 32'(s_b.valid), 32'd0);
    check("serr_data",  32'(s_b.data),  32'h0);
    sdv_b = 0; en_b = 1;
    tick();
    check("serr_clear", 32'(serr_b),   32'd0);
    check("fill_d1",    32'(s_b.data), 32'h1);
    tick();
    check("fill_d2",    32'(s_b.data),  32'h3);
    check("fill_v2",    32'(s_b.valid), 32'd0);
    sdv_b = 1; sd_b = 4'hA;
    tick();
    check("seed_data",  32'(s_b.data),  32'hA);
    check("seed_valid", 32'(s_b.valid), 32'd0);
    check("seed_serr",  32'(serr_b),    32'd0);
    sdv_b = 0;
    exp_b = '{4'h4, 4'h8, 4'h0, 4'h1};
    for (int i = 0; i < 4; i++) begin
      tick();
      check("reseed_data",  32'(s_b.data),  32'(exp_b[i]));
      check("reseed_valid", 32'(s_b.valid), 32'(i == 3));
      check("reseed_wrap",  32'(wrap_b),    32'd0);
    end

    // Seed load in the same cycle as a handshake.
    s_b.ready = 1; sdv_b = 1; sd_b = 4'h6;
    tick();
    check("sh_valid", 32'(s_b.valid), 32'd0);
    check("sh_data",  32'(s_b.data),  32'h6);
    sdv_b = 0;
    exp_b = '{4'hC, 4'h9, 4'h2, 4'h5};
    for (int i = 0; i < 4; i++) begin
      tick();
      check("sh_fill_data",  32'(s_b.data),  32'(exp_b[i]));
      check("sh_fill_valid", 32'(s_b.valid), 32'(i == 3));
    end
    en_b = 0; s_b.ready = 0;

    // 16-bit: toggled enable, valid after 8 enabled cycles.
    for (int i = 1; i <= 16; i++) begin
      en_c = (i % 2 == 1);
      tick();
      check("c_valid", 32'(s_c.valid), 32'(i >= 15));
      if (i >= 15) check("c_data", 32'(s_c.data), 32'hF0);
    end
    s_c.ready = 1; en_c = 1;
    tick();
    check("c_hs_valid", 32'(s_c.valid), 32'd0);
    s_c.ready = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("c2_valid", 32'(s_c.valid), 32'(i == 8));
    end
    check("c2_data", 32'(s_c.data), 32'hF6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
